// File: rtl/ind_seq_checker.sv
// ind_seq_checker: tracks the 8-step indicator code cycle, acquires lock and counts sequence errors
module ind_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ind_in,
  input  logic             ind_vld,
  input  logic             clr_err,
  output logic             locked,
  output logic [2:0]       pos,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
  state_t           state_q, state_d;
  logic [3:0]       good_q, good_d, bad_q, bad_d;
  logic [2:0]       prev_q, prev_d, pos_q, pos_d, idx;
  logic             locked_q, locked_d, err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             is_good, is_hold, is_bad, err_ev;
  // map indicator code to its position in the cycle
  always_comb begin
    case (ind_in)
      3'b000:  idx = 3'd0;
      3'b010:  idx = 3'd1;
      3'b111:  idx = 3'd2;
      3'b100:  idx = 3'd3;
      3'b101:  idx = 3'd4;
      3'b001:  idx = 3'd5;
      3'b011:  idx = 3'd6;
      default: idx = 3'd7;
    endcase
  end
  // classify the step against the previous valid sample; 3-bit add wraps 7->0
  always_comb begin
    is_good = idx == 3'(prev_q + 3'd1);
    is_hold = idx == prev_q;
    is_bad  = !is_good && !is_hold;
  end
  // next state, step counters and error accounting
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    err_ev  = 1'b0;
    if (ind_vld) begin
      prev_d = idx;
      pos_d  = idx;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          good_d  = 4'd0;
        end
        ACQ: begin
          if (is_good) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCK;
              bad_d   = 4'd0;
            end
          end else if (is_bad) good_d = 4'd0;
        end
        LOCK: begin
          if (is_good) bad_d = 4'd0;
          else if (is_bad) begin
            err_ev = 1'b1;
            bad_d  = bad_q + 4'd1;
            if (bad_q + 4'd1 == 4'(LOSS_CNT)) begin
              state_d = ACQ;
              good_d  = 4'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d    = state_d == LOCK;
    err_pulse_d = err_ev;
    err_cnt_d   = clr_err ? ERR_W'(err_ev) : err_cnt_q + ERR_W'(err_ev && !(&err_cnt_q));
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      good_q      <= 4'd0;
      bad_q       <= 4'd0;
      prev_q      <= 3'd0;
      pos_q       <= 3'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      prev_q      <= prev_d;
      pos_q       <= pos_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign locked    = locked_q;
  assign pos       = pos_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ind_seq_checker.sv
// tb_ind_seq_checker: directed checks of lock, error counting, hold, gaps and reset
module tb_ind_seq_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ind_in = 3'd0;
  logic       ind_vld = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [2:0] pos, pos2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] enc [8];
  int vectors = 0;
  int miscompares = 0;

  ind_seq_checker dut (
    .clk(clk), .rst(rst), .ind_in(ind_in), .ind_vld(ind_vld), .clr_err(clr_err),
    .locked(locked), .pos(pos), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );
  ind_seq_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .ind_in(ind_in), .ind_vld(ind_vld), .clr_err(clr_err),
    .locked(locked2), .pos(pos2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic step(input int i, input logic v, input logic c);
    ind_in  = enc[i % 8];
    ind_vld = v;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic lock_from(input int s);
    for (int i = 0; i < 5; i++) step(s + i, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({locked, pos, err_pulse, err_cnt} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got locked=%0b pos=%0d pulse=%0b cnt=%0d exp all 0", locked, pos, err_pulse, err_cnt);
    end
  endtask

  task automatic test_acquire();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(i, 1'b1, 1'b0);
      vectors++;
      if (pos !== 3'(i) || locked !== (i == 4) || err_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL acquire[%0d] got pos=%0d locked=%0b cnt=%0d exp pos=%0d locked=%0b cnt=0", i, pos, locked, err_cnt, i, i == 4);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    lock_from(0);
    for (int i = 5; i <= 10; i++) step(i, 1'b1, 1'b0);
    vectors++;
    if (locked !== 1'b1 || pos !== 3'd2) begin
      miscompares++;
      $display("FAIL err_pre got locked=%0b pos=%0d exp locked=1 pos=2", locked, pos);
    end
    step(4, 1'b1, 1'b0);
    vectors++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL err_first got pulse=%0b cnt=%0d locked=%0b exp 1 1 1", err_pulse, err_cnt, locked);
    end
    step(0, 1'b1, 1'b0);
    vectors++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL err_second got pulse=%0b cnt=%0d locked=%0b exp 1 2 0", err_pulse, err_cnt, locked);
    end
    step(0, 1'b0, 1'b0);
    vectors++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL err_idle got pulse=%0b cnt=%0d locked=%0b exp 0 2 0", err_pulse, err_cnt, locked);
    end
  endtask

  task automatic test_hold();
    do_reset();
    lock_from(7);
    for (int k = 0; k < 5; k++) begin
      step(3, 1'b1, 1'b0);
      vectors++;
      if (err_pulse !== 1'b0 || locked !== 1'b1 || pos !== 3'd3) begin
        miscompares++;
        $display("FAIL hold[%0d] got pulse=%0b locked=%0b pos=%0d exp 0 1 3", k, err_pulse, locked, pos);
      end
    end
    for (int i = 4; i <= 7; i++) step(i, 1'b1, 1'b0);
    step(8, 1'b1, 1'b0);
    vectors++;
    if (pos !== 3'd0 || locked !== 1'b1 || err_pulse !== 1'b0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap got pos=%0d locked=%0b pulse=%0b cnt=%0d exp 0 1 0 0", pos, locked, err_pulse, err_cnt);
    end
  endtask

  task automatic test_saturate();
    int cur;
    logic [1:0] e2;
    do_reset();
    lock_from(0);
    cur = 4;
    for (int k = 1; k <= 6; k++) begin
      cur += 2;
      step(cur, 1'b1, 1'b0);
      e2 = 2'(k > 3 ? 3 : k);
      vectors++;
      if (err_cnt2 !== e2 || err_pulse !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_bad[%0d] got cnt2=%0d pulse=%0b exp cnt2=%0d pulse=1", k, err_cnt2, err_pulse, e2);
      end
      cur += 1;
      step(cur, 1'b1, 1'b0);
      vectors++;
      if (locked !== 1'b1 || locked2 !== 1'b1 || err_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_good[%0d] got locked=%0b locked2=%0b pulse=%0b exp 1 1 0", k, locked, locked2, err_pulse);
      end
    end
    vectors++;
    if (err_cnt !== 8'd6) begin
      miscompares++;
      $display("FAIL sat_wide got cnt=%0d exp 6", err_cnt);
    end
    cur += 2;
    step(cur, 1'b1, 1'b1);
    vectors++;
    if (err_cnt2 !== 2'd1 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_with_err got cnt2=%0d cnt=%0d exp 1 1", err_cnt2, err_cnt);
    end
  endtask

  task automatic test_vld_gap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(i, 1'b1, 1'b0);
      vectors++;
      if (locked !== (i == 4) || pos !== 3'(i)) begin
        miscompares++;
        $display("FAIL gap_vld[%0d] got locked=%0b pos=%0d exp %0b %0d", i, locked, pos, i == 4, i);
      end
      step(6, 1'b0, 1'b0);
      vectors++;
      if (locked !== (i == 4) || pos !== 3'(i) || err_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_idle[%0d] got locked=%0b pos=%0d pulse=%0b exp %0b %0d 0", i, locked, pos, err_pulse, i == 4, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cur;
    do_reset();
    lock_from(0);
    cur = 4;
    for (int k = 0; k < 5; k++) begin
      cur += 2;
      step(cur, 1'b1, 1'b0);
      cur += 1;
      step(cur, 1'b1, 1'b0);
    end
    vectors++;
    if (err_cnt !== 8'd5 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre got cnt=%0d locked=%0b exp 5 1", err_cnt, locked);
    end
    rst = 1'b1;
    step(cur + 2, 1'b1, 1'b0);
    rst = 1'b0;
    vectors++;
    if ({locked, pos, err_pulse, err_cnt} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_reset got locked=%0b pos=%0d pulse=%0b cnt=%0d exp all 0", locked, pos, err_pulse, err_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      step(i + 3, 1'b1, 1'b0);
      vectors++;
      if (locked !== (i == 4)) begin
        miscompares++;
        $display("FAIL reacquire[%0d] got locked=%0b exp %0b", i, locked, i == 4);
      end
    end
  endtask

  initial begin
    enc = '{3'b000, 3'b010, 3'b111, 3'b100, 3'b101, 3'b001, 3'b011, 3'b110};
    test_reset();
    test_acquire();
    test_errors();
    test_hold();
    test_saturate();
    test_vld_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
